// File: rtl/tile_plot_arbiter.sv
// tile_plot_arbiter
//   Four-way round-robin arbiter that owns a vga_adapter pixel port. The
//   winning requester gets a rectangular TILE_W x TILE_H solid fill at its
//   latched origin and colour, one pixel per clock in row-major order,
//   followed by a one-cycle done pulse.
//
//   FSM: IDLE -> FILL (TILE_W*TILE_H cycles) -> DONE (1 cycle) -> IDLE.
//   All outputs are registered; the pixel shown in a FILL cycle is the one
//   addressed by the xc/yc counters held in that same cycle.
//
//   Optional feature (compile-time macro TILE_PLOT_ARBITER_CLIP_EN):
//     defined   - pixels with x0+xc >= XSCREEN or y0+yc >= YSCREEN keep their
//                 cycle but drive plot=0.
//     undefined - every FILL pixel plots; coordinates wrap to 8/7 bits.
//
// Ports
//   CLOCK_50    in   sole clock, rising edge
//   reset       in   synchronous active-high reset
//   req[3:0]    in   level request per requester
//   req_x       in   8-bit tile origin X per requester, packed [8i+7:8i]
//   req_y       in   7-bit tile origin Y per requester, packed [7i+6:7i]
//   req_colour  in   3-bit fill colour per requester, packed [3i+2:3i]
//   gnt[3:0]    out  one-hot grant, high for the whole fill
//   done[3:0]   out  one-cycle completion pulse to the granted requester
//   busy        out  high whenever the FSM is not in IDLE
//   plot        out  pixel write strobe
//   vga_x/y     out  pixel coordinate
//   vga_colour  out  pixel colour
module tile_plot_arbiter #(
  parameter int TILE_W  = 10,
  parameter int TILE_H  = 10,
  parameter int XSCREEN = 160,
  parameter int YSCREEN = 120
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic [3:0]  req,
  input  logic [31:0] req_x,
  input  logic [27:0] req_y,
  input  logic [11:0] req_colour,
  output logic [3:0]  gnt,
  output logic [3:0]  done,
  output logic        busy,
  output logic        plot,
  output logic [7:0]  vga_x,
  output logic [6:0]  vga_y,
  output logic [2:0]  vga_colour
);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} state_t;

  localparam logic [3:0] XC_LAST = 4'(TILE_W - 1);
  localparam logic [3:0] YC_LAST = 4'(TILE_H - 1);

  // With clipping the sums carry one extra bit so off-screen pixels can be
  // detected; without it the sums are formed at output width and wrap.
`ifdef TILE_PLOT_ARBITER_CLIP_EN
  localparam int XSW = 9;
  localparam int YSW = 8;
`else
  localparam int XSW = 8;
  localparam int YSW = 7;
`endif

  state_t       state;
  logic [1:0]   rr_ptr;    // first requester examined by the next search
  logic [1:0]   win;
  logic [7:0]   x0;
  logic [6:0]   y0;
  logic [2:0]   col;
  logic [3:0]   xc;
  logic [3:0]   yc;

  logic [1:0]   sel;
  logic [1:0]   cand;
  logic         found;
  logic [7:0]   sel_x;
  logic [6:0]   sel_y;
  logic [2:0]   sel_col;
  logic [3:0]   nxc;
  logic [3:0]   nyc;
  logic [7:0]   src_x;
  logic [6:0]   src_y;
  logic [3:0]   src_xc;
  logic [3:0]   src_yc;
  logic [XSW-1:0] sum_x;
  logic [YSW-1:0] sum_y;
  logic         pix_plot;
  logic         last_pix;

  // Round-robin search: ascending from rr_ptr with wrap, first hit wins.
  always_comb begin
    sel   = '0;
    cand  = '0;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cand = rr_ptr + 2'(i);
      if (!found && req[cand]) begin
        sel   = cand;
        found = 1'b1;
      end
    end
  end

  // Unpack the selected requester's origin and colour.
  always_comb begin
    sel_x   = '0;
    sel_y   = '0;
    sel_col = '0;
    for (int i = 0; i < 4; i++) begin
      if (sel == 2'(i)) begin
        sel_x   = req_x[8*i +: 8];
        sel_y   = req_y[7*i +: 7];
        sel_col = req_colour[3*i +: 3];
      end
    end
  end

  // Next pixel: from IDLE it is (0,0) of the incoming tile, from FILL it is
  // the row-major successor of the current counters.
  always_comb begin
    last_pix = (xc == XC_LAST) && (yc == YC_LAST);
    if (xc == XC_LAST) begin
      nxc = '0;
      nyc = yc + 4'd1;
    end else begin
      nxc = xc + 4'd1;
      nyc = yc;
    end
    if (state == S_IDLE) begin
      src_x  = sel_x;
      src_y  = sel_y;
      src_xc = '0;
      src_yc = '0;
    end else begin
      src_x  = x0;
      src_y  = y0;
      src_xc = nxc;
      src_yc = nyc;
    end
    sum_x = XSW'(src_x) + XSW'(src_xc);
    sum_y = YSW'(src_y) + YSW'(src_yc);
`ifdef TILE_PLOT_ARBITER_CLIP_EN
    pix_plot = (int'(sum_x) < XSCREEN) && (int'(sum_y) < YSCREEN);
`else
    pix_plot = 1'b1;
`endif
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state      <= S_IDLE;
      rr_ptr     <= '0;
      win        <= '0;
      x0         <= '0;
      y0         <= '0;
      col        <= '0;
      xc         <= '0;
      yc         <= '0;
      gnt        <= '0;
      done       <= '0;
      busy       <= 1'b0;
      plot       <= 1'b0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
    end else begin
      done <= '0;
      case (state)
        S_IDLE: begin
          if (|req) begin
            state      <= S_FILL;
            win        <= sel;
            rr_ptr     <= sel + 2'd1;  // winner drops to lowest priority
            x0         <= sel_x;
            y0         <= sel_y;
            col        <= sel_col;
            xc         <= '0;
            yc         <= '0;
            gnt        <= 4'b0001 << sel;
            busy       <= 1'b1;
            plot       <= pix_plot;
            vga_x      <= sum_x[7:0];
            vga_y      <= sum_y[6:0];
            vga_colour <= sel_col;
          end else begin
            gnt        <= '0;
            busy       <= 1'b0;
            plot       <= 1'b0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
          end
        end
        S_FILL: begin
          if (last_pix) begin
            state      <= S_DONE;
            xc         <= '0;
            yc         <= '0;
            gnt        <= '0;
            done       <= 4'b0001 << win;
            plot       <= 1'b0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
          end else begin
            xc         <= nxc;
            yc         <= nyc;
            plot       <= pix_plot;
            vga_x      <= sum_x[7:0];
            vga_y      <= sum_y[6:0];
            vga_colour <= col;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          gnt   <= '0;
          busy  <= 1'b0;
          plot  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/tile_plot_arbiter.md
TILE_PLOT_ARBITER -- requirements
Module: tile_plot_arbiter

Interface
REQ-001 Parameter TILE_W, default 10: tile width in pixels, range 1..16.
REQ-002 Parameter TILE_H, default 10: tile height in pixels, range 1..16.
REQ-003 Parameter XSCREEN, default 160: visible width, used for clipping.
REQ-004 Parameter YSCREEN, default 120: visible height, used for clipping.
REQ-005 One clock; reset is synchronous and active-high.
REQ-006 CLOCK_50  input  1  sole clock, rising edge.
REQ-007 reset  input  1  synchronous active-high reset.
REQ-008 req  input  4  per-requester tile-fill request, level, bit i = requester i.
REQ-009 req_x  input  32  tile origin X, 8 bits per requester, requester i at [8i+7:8i].
REQ-010 req_y  input  28  tile origin Y, 7 bits per requester, requester i at [7i+6:7i].
REQ-011 req_colour  input  12  fill colour, 3 bits per requester, requester i at [3i+2:3i].
REQ-012 gnt  output  4  one-hot grant, high for the whole fill of the owning requester.
REQ-013 done  output  4  one-cycle completion pulse to the granted requester.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 plot  output  1  pixel write strobe to vga_adapter.
REQ-016 vga_x  output  8  pixel X to vga_adapter.
REQ-017 vga_y  output  7  pixel Y to vga_adapter.
REQ-018 vga_colour  output  3  pixel colour to vga_adapter.

Function
REQ-019 FSM states: IDLE, FILL, DONE. No other states are reachable.
REQ-020 IDLE with req != 0: select winner, latch its x/y/colour, clear counters xc=yc=0, enter FILL next edge; gnt[winner] rises on that edge.
REQ-021 IDLE with req == 0: remain IDLE, all outputs 0.
REQ-022 Round-robin: search starts at (last_winner+1) mod 4, ascending with wrap; pointer resets to search-start 0.
REQ-023 FILL: one pixel per cycle; vga_x = x0+xc, vga_y = y0+yc, vga_colour = latched colour, plot = 1 (subject to REQ-027).
REQ-024 xc increments 0..TILE_W-1; at TILE_W-1, xc returns to 0 and yc increments; row-major order.
REQ-025 Pixel (TILE_W-1, TILE_H-1) is the last FILL cycle; next edge enters DONE. A fill is exactly TILE_W*TILE_H FILL cycles.
REQ-026 DONE: done[winner]=1 for one cycle, gnt=0, plot=0; next edge enters IDLE. Earliest re-grant lands 2 cycles after DONE is entered.
REQ-027 Coordinate sums are formed 9/8 bits wide; see Configuration for out-of-range pixels.
REQ-028 Latched x/y/colour are frozen during FILL; changes on req_x/req_y/req_colour are ignored until the next grant.
REQ-029 Deassertion of req[winner] during FILL is ignored; the fill completes and done still pulses.
REQ-030 Requests arriving during FILL or DONE wait; none are lost while held; a requester must keep req high until its done.
REQ-031 Requester still asserting req after its done competes again at lowest priority (round-robin).

Reset
REQ-032 When reset is sampled high, the next state is IDLE; gnt, done, busy, plot, vga_x, vga_y, and vga_colour are 0; counters are 0; the RR pointer is 0.
REQ-033 Reset mid-FILL aborts the fill; no done pulse is emitted for the aborted tile.

Configuration
REQ-034 Macro TILE_PLOT_ARBITER_CLIP_EN defined: a pixel whose X sum >= XSCREEN or Y sum >= YSCREEN drives plot=0 but still consumes its cycle; fill length is unchanged.
REQ-035 Macro TILE_PLOT_ARBITER_CLIP_EN undefined: plot=1 for every FILL pixel; vga_x/vga_y are the sums truncated to 8/7 bits (wrap).

Verification
REQ-036 req=0001, x0=30, y0=30, colour=100 -> gnt=0001 next cycle; 100 plot cycles covering (30..39, 30..39) in row-major order; done=0001 pulse; busy low 2 cycles later.
REQ-037 req=1111 held throughout -> grant order 0,1,2,3,0; each grant spans exactly 100 plot cycles plus 1 DONE cycle plus 1 IDLE cycle.
REQ-038 req[1] is dropped at FILL cycle 20 -> all 100 pixels are still plotted; done[1] still pulses.
REQ-039 Reset is asserted at FILL cycle 50 of requester 2 -> all outputs are 0 next cycle; no done; the next grant with req=0100 starts again at pixel (x0,y0).
REQ-040 CLIP_EN defined with x0=155, y0=115 -> plot=1 only for 25 pixels (155..159, 115..119); the fill still lasts 100 cycles. CLIP_EN undefined -> 100 plots with wrapped coordinates.
REQ-041 req=0010 is asserted on the DONE cycle of requester 0 -> gnt=0010 is asserted exactly 2 cycles after DONE is entered.
